ps2_scancode_decoder: RTL and testbench
=======================================

// Module: ps2_scancode_decoder
// PURPOSE
//  Consumer of the PS/2 receiver's {data_out, new_code}. Collapses raw scan-code bytes
//  (set 2, E0/F0 prefixes) into single key events {code, extended, release}, buffers them
//  in a small FIFO with a valid/ready handshake to the block-motion logic, and keeps
//  held-state flags for the four arrow keys that drive block movement on the VGA screen.
// PARAMETERS
//  FIFO_DEPTH      4          event FIFO entries; power of two, >= 2
//  TIMEOUT_CYCLES  2500000    clock_fpga cycles a prefix may wait for the next byte (50 ms @ 50 MHz)
// PORTS
//  clock_fpga    in   1   system clock; all state on rising edge
//  reset         in   1   asynchronous, active-low; 0 clears all state immediately
//  scan_code     in   8   received byte; stable while new_code is high
//  new_code      in   1   byte-available level; may stay high for many cycles
//  evt_valid     out  1   FIFO head holds an event
//  evt_ready     in   1   consumer accepts head when evt_valid & evt_ready at rising edge
//  evt_code      out  8   head event scan code (prefixes stripped)
//  evt_extended  out  1   head event was E0-prefixed
//  evt_release   out  1   head event was F0-prefixed (break)
//  key_up        out  1   1 while E0 75 held
//  key_down      out  1   1 while E0 72 held
//  key_left      out  1   1 while E0 6B held
//  key_right     out  1   1 while E0 74 held
//  overflow      out  1   sticky: an event was dropped because FIFO was full
// BEHAVIOUR
//  - Reset: FSM=IDLE, FIFO empty, timeout counter 0, edge register 0; every output 0.
//  - Byte strobe: new_code registered once; strobe = new_code & ~new_code_q. One byte per
//    rising edge of new_code; a level held high never yields a second strobe.
//  - FSM (advances only on strobe, except timeout):
//    IDLE:    E0->GOT_E0; F0->GOT_F0; other->emit{b,0,0}
//    GOT_E0:  F0->GOT_E0F0; E0->GOT_E0; other->emit{b,1,0}, IDLE
//    GOT_F0:  F0->GOT_F0; E0->GOT_E0; other->emit{b,0,1}, IDLE
//    GOT_E0F0:F0/E0 stay; other->emit{b,1,1}, IDLE
//  - Timeout: counter runs in any non-IDLE state, cleared on strobe/IDLE; reaching
//    TIMEOUT_CYCLES-1 without a strobe forces IDLE, nothing emitted.
//  - Prefix bytes never produce events. Typematic repeats produce one event per make byte.
//  - Emit at strobe edge N: pushed into FIFO and arrow flags updated at that edge;
//    evt_valid / key_* visible at N+1 (1-cycle latency from strobe).
//  - Arrow flags: set on extended make of their code, cleared on extended break; non-
//    extended 75/72/6B/74 (keypad) do not touch them.
//  - FIFO: first-word-fall-through, head registered; events popped strictly in order.
//    Full and no pop: new event dropped, overflow<=1 (sticky until reset).
//    Full with pop same edge: push accepted, level unchanged. Empty: evt_valid=0, evt_*
//    hold last value (don't-care). evt_ready while empty ignored.
//  - Reset asserted mid-sequence discards prefixes and queued events; no partial event.
// STRUCTURE
//  - ps2_codes.vh: localparams CODE_EXT=8'hE0, CODE_BRK=8'hF0, KEY_UP=8'h75,
//    KEY_DOWN=8'h72, KEY_LEFT=8'h6B, KEY_RIGHT=8'h74, FSM state encodings, EVT_W=10.
//  - Sub-module event_fifo (WIDTH=EVT_W, DEPTH=FIFO_DEPTH): sync FIFO with push/pop,
//    full/empty, async active-low reset. FSM, strobe, timeout, flags in top level.
// TESTING (bench uses TIMEOUT_CYCLES=16, FIFO_DEPTH=4)
//  1. new_code 0->1 with scan_code=1C, evt_ready=1 -> one cycle later evt_valid=1,
//     evt_code=1C, extended=0, release=0; popped next edge; no second event while held.
//  2. Bytes E0,75 -> evt {75,1,0}, key_up=1; then E0,F0,75 -> evt {75,1,1}, key_up=0;
//     exactly two events total, none for prefixes.
//  3. evt_ready=0, five make bytes 11,12,13,14,15 -> overflow=1, evt_valid=1; raising
//     evt_ready pops 11,12,13,14 in order, 15 never appears.
//  4. FIFO full, pop and new strobe (16) on same edge -> level stays 4, 16 later at tail.
//  5. E0, idle 20 cycles, then 1C -> evt {1C,0,0} (prefix timed out), key_* unchanged.
//  6. E0 then reset=0 for 2 cycles -> all outputs 0 asynchronously; after release,
//     byte 75 -> evt {75,0,0}, key_up stays 0.

Source files
------------

// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared scan-code constants, FSM states and the packed key-event record for the PS/2 decoder.
package ps2_scancode_decoder_pkg;

   localparam logic [7:0] CODE_EXT  = 8'hE0;
   localparam logic [7:0] CODE_BRK  = 8'hF0;
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;

   localparam int unsigned EVT_W = 10;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StGotE0   = 2'd1,
      StGotF0   = 2'd2,
      StGotE0F0 = 2'd3
   } ps2_state_e;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } ps2_evt_t;

endpackage

// File: rtl/ps2_scancode_decoder_event_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted only alongside a pop.
module event_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Collapses set-2 scan-code bytes into key events, queues them, and tracks arrow-key hold state.
module ps2_scancode_decoder
   import ps2_scancode_decoder_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
   input  logic       clock_fpga,
   input  logic       reset,
   input  logic [7:0] scan_code,
   input  logic       new_code,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_extended,
   output logic       evt_release,
   output logic       key_up,
   output logic       key_down,
   output logic       key_left,
   output logic       key_right,
   output logic       overflow
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   ps2_state_e       state_q, state_d;
   logic             new_code_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       keys_q, keys_d;
   logic             overflow_q, overflow_d;
   logic             strobe, is_prefix, timeout_hit, emit;
   ps2_evt_t         evt_d, evt_head;
   logic [EVT_W-1:0] fifo_rdata;
   logic             fifo_full, fifo_empty;

   assign strobe      = new_code & ~new_code_q;
   assign is_prefix   = (scan_code == CODE_EXT) || (scan_code == CODE_BRK);
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock_fpga or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (strobe) begin
         unique case (state_q)
            StIdle: begin
               if (scan_code == CODE_EXT)      state_d = StGotE0;
               else if (scan_code == CODE_BRK) state_d = StGotF0;
            end
            StGotE0: begin
               if (scan_code == CODE_BRK)      state_d = StGotE0F0;
               else if (!is_prefix)            state_d = StIdle;
            end
            StGotF0: begin
               if (scan_code == CODE_EXT)      state_d = StGotE0;
               else if (!is_prefix)            state_d = StIdle;
            end
            StGotE0F0: begin
               if (!is_prefix)                 state_d = StIdle;
            end
         endcase
      end else if (state_q != StIdle && timeout_hit) begin
         state_d = StIdle;
      end
   end

   always_comb begin
      emit       = strobe & ~is_prefix;
      evt_d.code = scan_code;
      evt_d.ext  = (state_q == StGotE0) || (state_q == StGotE0F0);
      evt_d.brk  = (state_q == StGotF0) || (state_q == StGotE0F0);
   end

   // Prefix timer: restarts on every byte so only a silent line can abandon a prefix.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (state_q == StIdle || strobe || timeout_hit) cnt_d = '0;
   end

   always_comb begin
      keys_d     = keys_q;
      overflow_d = overflow_q | (emit & fifo_full & ~(evt_valid & evt_ready));
      if (emit && evt_d.ext) begin
         case (scan_code)
            KEY_UP:    keys_d[3] = ~evt_d.brk;
            KEY_DOWN:  keys_d[2] = ~evt_d.brk;
            KEY_LEFT:  keys_d[1] = ~evt_d.brk;
            KEY_RIGHT: keys_d[0] = ~evt_d.brk;
            default:   keys_d    = keys_q;
         endcase
      end
   end

   always_ff @(posedge clock_fpga or negedge reset) begin
      if (!reset) begin
         new_code_q <= 1'b0;
         cnt_q      <= '0;
         keys_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         new_code_q <= new_code;
         cnt_q      <= cnt_d;
         keys_q     <= keys_d;
         overflow_q <= overflow_d;
      end
   end

   event_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clock_fpga),
      .rst_ni  (reset),
      .push_i  (emit),
      .data_i  (evt_d),
      .pop_i   (evt_ready),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign evt_head     = ps2_evt_t'(fifo_rdata);
   assign evt_valid    = ~fifo_empty;
   assign evt_code     = evt_head.code;
   assign evt_extended = evt_head.ext;
   assign evt_release  = evt_head.brk;
   assign key_up       = keys_q[3];
   assign key_down     = keys_q[2];
   assign key_left     = keys_q[1];
   assign key_right    = keys_q[0];
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: vector table, directed corner cases, randomized run vs model.
module tb_ps2_scancode_decoder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TO    = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] scan_code = 8'h00;
   logic       new_code = 1'b0;
   logic       evt_ready = 1'b0;
   logic       evt_valid, evt_extended, evt_release, overflow;
   logic [7:0] evt_code;
   logic       key_up, key_down, key_left, key_right;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ps2_scancode_decoder #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock_fpga   (clk),
      .reset        (reset),
      .scan_code    (scan_code),
      .new_code     (new_code),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_code     (evt_code),
      .evt_extended (evt_extended),
      .evt_release  (evt_release),
      .key_up       (key_up),
      .key_down     (key_down),
      .key_left     (key_left),
      .key_right    (key_right),
      .overflow     (overflow)
   );

   typedef struct {
      int             n;
      logic [4:0][7:0] b;
      logic [7:0]     code;
      logic           ext;
      logic           brk;
      logic [3:0]     keys;
   } vec_t;

   vec_t tbl [13];

   function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2, b3, b4,
                               input logic [7:0] code, input logic ext, brk,
                               input logic [3:0] keys);
      vec_t v;
      v.n = n;
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
      v.code = code; v.ext = ext; v.brk = brk; v.keys = keys;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] keys_now();
      return {key_up, key_down, key_left, key_right};
   endfunction

   // All tasks start and end just after a falling edge.
   task automatic send_byte(input logic [7:0] b);
      scan_code = b;
      new_code  = 1'b1;
      @(negedge clk);
      new_code  = 1'b0;
      @(negedge clk);
   endtask

   task automatic pop_one();
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   task automatic do_reset();
      new_code  = 1'b0;
      evt_ready = 1'b0;
      reset     = 1'b0;
      repeat (2) @(negedge clk);
      reset     = 1'b1;
      @(negedge clk);
   endtask

   task automatic chk_head(input string nm, input logic [7:0] c, input logic e, input logic r);
      chk({nm, "_valid"}, evt_valid, 1'b1);
      chk({nm, "_code"}, evt_code, c);
      chk({nm, "_ext"}, evt_extended, e);
      chk({nm, "_rel"}, evt_release, r);
   endtask

   // Reference model: pending-prefix flags plus a queue, updated once per clock edge.
   logic [9:0] mq[$];
   bit         m_ext, m_brk, m_ovf, m_prev;
   bit [3:0]   m_keys;
   int         m_wait;

   task automatic model_step(input bit nc, input logic [7:0] sc, input bit rdy);
      bit strobe;
      strobe = nc && !m_prev;
      m_prev = nc;
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (strobe) begin
         m_wait = 0;
         if (sc == 8'hE0) begin
            if (m_brk && !m_ext) m_brk = 1'b0;
            m_ext = 1'b1;
         end else if (sc == 8'hF0) begin
            m_brk = 1'b1;
         end else begin
            if (mq.size() < int'(DEPTH)) mq.push_back({sc, m_ext, m_brk});
            else m_ovf = 1'b1;
            if (m_ext) begin
               if (sc == 8'h75) m_keys[3] = !m_brk;
               if (sc == 8'h72) m_keys[2] = !m_brk;
               if (sc == 8'h6B) m_keys[1] = !m_brk;
               if (sc == 8'h74) m_keys[0] = !m_brk;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
         end
      end else if (m_ext || m_brk) begin
         if (m_wait == int'(TO) - 1) begin
            m_ext = 1'b0; m_brk = 1'b0; m_wait = 0;
         end else begin
            m_wait++;
         end
      end
   endtask

   function automatic logic [7:0] rand_byte();
      logic [7:0] pool [8];
      pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'h00};
      pool[7] = 8'($urandom_range(0, 255));
      return pool[$urandom_range(0, 7)];
   endfunction

   initial begin
      tbl[0]  = mk(1, 8'h1C, 0, 0, 0, 0, 8'h1C, 0, 0, 4'b0000);
      tbl[1]  = mk(2, 8'hE0, 8'h75, 0, 0, 0, 8'h75, 1, 0, 4'b1000);
      tbl[2]  = mk(2, 8'hE0, 8'h72, 0, 0, 0, 8'h72, 1, 0, 4'b1100);
      tbl[3]  = mk(2, 8'hE0, 8'h6B, 0, 0, 0, 8'h6B, 1, 0, 4'b1110);
      tbl[4]  = mk(2, 8'hE0, 8'h74, 0, 0, 0, 8'h74, 1, 0, 4'b1111);
      tbl[5]  = mk(1, 8'h75, 0, 0, 0, 0, 8'h75, 0, 0, 4'b1111);
      tbl[6]  = mk(3, 8'hE0, 8'hF0, 8'h75, 0, 0, 8'h75, 1, 1, 4'b0111);
      tbl[7]  = mk(2, 8'hF0, 8'h72, 0, 0, 0, 8'h72, 0, 1, 4'b0111);
      tbl[8]  = mk(3, 8'hF0, 8'hE0, 8'h72, 0, 0, 8'h72, 1, 0, 4'b0111);
      tbl[9]  = mk(3, 8'hE0, 8'hF0, 8'h72, 0, 0, 8'h72, 1, 1, 4'b0011);
      tbl[10] = mk(5, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h6B, 8'h6B, 1, 1, 4'b0001);
      tbl[11] = mk(3, 8'hF0, 8'hF0, 8'h1C, 0, 0, 8'h1C, 0, 1, 4'b0001);
      tbl[12] = mk(4, 8'hE0, 8'hF0, 8'hE0, 8'h74, 0, 8'h74, 1, 1, 4'b0000);

      @(negedge clk);
      do_reset();
      chk("rst_valid", evt_valid, 1'b0);
      chk("rst_keys", keys_now(), 4'b0000);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_code", evt_code, 8'h00);

      // Single make byte with level held high.
      scan_code = 8'h1C; new_code = 1'b1; evt_ready = 1'b1;
      @(negedge clk);
      chk_head("t1", 8'h1C, 1'b0, 1'b0);
      @(negedge clk);
      chk("t1_popped", evt_valid, 1'b0);
      repeat (4) @(negedge clk);
      chk("t1_held_no_second", evt_valid, 1'b0);
      new_code = 1'b0; evt_ready = 1'b0;
      @(negedge clk);

      // Vector table: each sequence yields exactly one event.
      do_reset();
      for (int i = 0; i < 13; i++) begin
         for (int j = 0; j < tbl[i].n; j++) send_byte(tbl[i].b[j]);
         chk_head($sformatf("tbl%0d", i), tbl[i].code, tbl[i].ext, tbl[i].brk);
         chk($sformatf("tbl%0d_keys", i), keys_now(), tbl[i].keys);
         pop_one();
         chk($sformatf("tbl%0d_single", i), evt_valid, 1'b0);
      end

      // Overflow: five makes into a four-deep queue.
      do_reset();
      for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
      chk("t3_ovf", overflow, 1'b1);
      chk("t3_valid", evt_valid, 1'b1);
      evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t3_pop%0d", i), evt_code, 8'h11 + 8'(i));
         @(negedge clk);
      end
      chk("t3_empty", evt_valid, 1'b0);
      evt_ready = 1'b0;

      // Full queue: pop and push on the same edge.
      do_reset();
      for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i));
      evt_ready = 1'b1; scan_code = 8'h16; new_code = 1'b1;
      @(negedge clk);
      new_code = 1'b0;
      begin
         logic [7:0] exp4 [4];
         exp4 = '{8'h22, 8'h23, 8'h24, 8'h16};
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_pop%0d", i), {evt_valid, evt_code}, {1'b1, exp4[i]});
            @(negedge clk);
         end
      end
      chk("t4_empty", evt_valid, 1'b0);
      chk("t4_no_ovf", overflow, 1'b0);
      evt_ready = 1'b0;

      // Prefix timeout.
      do_reset();
      send_byte(8'hE0); send_byte(8'h75); pop_one();
      chk("t5_up_set", key_up, 1'b1);
      send_byte(8'hE0);
      repeat (20) @(negedge clk);
      send_byte(8'h1C);
      chk_head("t5", 8'h1C, 1'b0, 1'b0);
      chk("t5_keys", keys_now(), 4'b1000);
      pop_one();

      // Asynchronous reset mid-sequence.
      send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_valid", evt_valid, 1'b0);
      chk("t6_async_code", evt_code, 8'h00);
      chk("t6_async_keys", keys_now(), 4'b0000);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      send_byte(8'h75);
      chk_head("t6", 8'h75, 1'b0, 1'b0);
      chk("t6_up", key_up, 1'b0);
      pop_one();

      // Randomized run against the model.
      do_reset();
      mq.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_prev = 0; m_keys = '0; m_wait = 0;
      begin
         int  hold;
         bit  nc;
         logic [7:0] sc;
         bit  rdy;
         hold = 2; nc = 0; sc = 8'h00; rdy = 0;
         for (int cyc = 0; cyc < 4000; cyc++) begin
            chk("rnd_valid", evt_valid, mq.size() > 0);
            if (mq.size() > 0) chk("rnd_head", {evt_code, evt_extended, evt_release}, mq[0]);
            chk("rnd_keys", keys_now(), m_keys);
            chk("rnd_ovf", overflow, m_ovf);
            if (hold == 0) begin
               nc = !nc;
               if (nc) begin
                  sc   = rand_byte();
                  hold = $urandom_range(0, 2);
               end else begin
                  hold = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(0, 3);
               end
            end else begin
               hold--;
            end
            rdy = ($urandom_range(0, 2) == 0);
            new_code = nc; scan_code = sc; evt_ready = rdy;
            model_step(nc, sc, rdy);
            @(negedge clk);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
